// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the fetch FSM state encoding and the constant branch-target table.
// Table entries are 10-bit two's complement values, sign-extended by the lookup.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int LUT_N = 8;
  localparam int LUT_W = 10;

  // Element [i] is table index i; listed from index 7 down to index 0.
  localparam logic [LUT_N-1:0][LUT_W-1:0] BRANCH_LUT = {
    10'h3F0,  // 7: -16
    10'h3F8,  // 6: -8
    10'h3FE,  // 5: -2
    10'h3FF,  // 4: -1
    10'd64,   // 3
    10'd32,   // 2
    10'd16,   // 1
    10'd0     // 0
  };

endpackage

// File: rtl/inst_fetch_branch_lut.sv
// Combinational branch-target lookup: LutIdx selects a BRANCH_LUT entry.
// Ports: LutIdx (D bits) in, Value (A bits) out; entries sign-extended to A bits.
// Indices beyond the table size return zero.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 3
) (
  input  logic [D-1:0] LutIdx,
  output logic [A-1:0] Value
);

  logic signed [LUT_W-1:0] entry;

  always_comb begin
    entry = '0;
    for (int i = 0; i < LUT_N; i++) begin
      if (LutIdx == D'(i)) entry = BRANCH_LUT[i[2:0]];
    end
  end

  // Sized cast of a signed value sign-extends (or truncates) to A bits.
  assign Value = A'(entry);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALTED FSM driving a registered program counter.
// Ports: Clk/Reset, Start+StartAddr to launch, Halt/BranchEn/Taken/RelMode/LutIdx
// from decode; outputs ProgCtr, Valid (RUN), Done (halted), CycleCount (RUN edges).
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  input  logic         Halt,
  input  logic         BranchEn,
  input  logic         Taken,
  input  logic         RelMode,
  input  logic [D-1:0] LutIdx,
  output logic [A-1:0] ProgCtr,
  output logic         Valid,
  output logic         Done,
  output logic [15:0]  CycleCount
);

  state_t       state;
  logic [A-1:0] lut_val;

  branch_lut #(.A(A), .D(D)) u_lut (
    .LutIdx (LutIdx),
    .Value  (lut_val)
  );

  assign Valid = (state == RUN);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      Done       <= 1'b0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= StartAddr;
            Done       <= 1'b0;
            CycleCount <= '0;
          end
        end
        RUN: begin
          // The halting edge is itself a RUN edge, so it is counted too.
          if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
          if (Halt) begin
            state <= HALTED;
            Done  <= 1'b1;
          end else if (BranchEn && Taken) begin
            // Relative add wraps modulo 2**A; the sign-extended entry makes it a subtract.
            ProgCtr <= RelMode ? (ProgCtr + lut_val) : lut_val;
          end else begin
            ProgCtr <= ProgCtr + A'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [9:0] StartAddr = '0;
  logic       Halt = 1'b0;
  logic       BranchEn = 1'b0;
  logic       Taken = 1'b0;
  logic       RelMode = 1'b0;
  logic [2:0] LutIdx = '0;
  logic [9:0] ProgCtr;
  logic       Valid;
  logic       Done;
  logic [15:0] CycleCount;

  int checks = 0;
  int failures = 0;

  inst_fetch #(.A(10), .D(3)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .Taken      (Taken),
    .RelMode    (RelMode),
    .LutIdx     (LutIdx),
    .ProgCtr    (ProgCtr),
    .Valid      (Valid),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] pc, input logic v,
                            input logic d, input logic [15:0] cc);
    chk({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
    chk({tag, ".valid"}, 32'(Valid), 32'(v));
    chk({tag, ".done"}, 32'(Done), 32'(d));
    chk({tag, ".cc"}, 32'(CycleCount), 32'(cc));
  endtask

  // From RUN: halt on the next edge, then launch at addr on the following edge.
  task automatic restart(input logic [9:0] addr);
    Halt = 1'b1; tick(); Halt = 1'b0;
    Start = 1'b1; StartAddr = addr; tick(); Start = 1'b0;
  endtask

  initial begin
    // Asynchronous reset, no clock edge yet.
    #2 Reset = 1'b1;
    #1 expect_out("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    tick();
    Reset = 1'b0;
    tick();
    expect_out("idle_hold", 10'd0, 1'b0, 1'b0, 16'd0);

    // Start at 5, sequential fetch.
    Start = 1'b1; StartAddr = 10'd5; tick(); Start = 1'b0;
    expect_out("seq0", 10'd5, 1'b1, 1'b0, 16'd0);
    tick(); expect_out("seq1", 10'd6, 1'b1, 1'b0, 16'd1);
    tick(); expect_out("seq2", 10'd7, 1'b1, 1'b0, 16'd2);

    // Plain halt; halting edge counts as a RUN edge.
    Halt = 1'b1; tick(); Halt = 1'b0;
    expect_out("halt_plain", 10'd7, 1'b0, 1'b1, 16'd3);
    tick(); expect_out("halted_stay", 10'd7, 1'b0, 1'b1, 16'd3);

    // PC wrap 1023 -> 0.
    Start = 1'b1; StartAddr = 10'd1022; tick(); Start = 1'b0;
    chk("wrap.pc1022", 32'(ProgCtr), 32'd1022);
    tick(); chk("wrap.pc1023", 32'(ProgCtr), 32'd1023);
    tick(); chk("wrap.pc0", 32'(ProgCtr), 32'd0);
    chk("wrap.valid", 32'(Valid), 32'd1);

    // Absolute branch, LUT[3]=64.
    restart(10'd40);
    chk("abs.start", 32'(ProgCtr), 32'd40);
    BranchEn = 1'b1; Taken = 1'b1; RelMode = 1'b0; LutIdx = 3'd3; tick();
    BranchEn = 1'b0; Taken = 1'b0;
    chk("abs.pc", 32'(ProgCtr), 32'd64);

    // Relative branch, LUT[6]=-8: 40-8=32.
    restart(10'd40);
    BranchEn = 1'b1; Taken = 1'b1; RelMode = 1'b1; LutIdx = 3'd6; tick();
    BranchEn = 1'b0; Taken = 1'b0; RelMode = 1'b0;
    chk("rel.pc", 32'(ProgCtr), 32'd32);

    // Relative branch, LUT[1]=+16 from 32 -> 48.
    BranchEn = 1'b1; Taken = 1'b1; RelMode = 1'b1; LutIdx = 3'd1; tick();
    BranchEn = 1'b0; Taken = 1'b0; RelMode = 1'b0;
    chk("rel_pos.pc", 32'(ProgCtr), 32'd48);

    // Branch not taken -> sequential.
    restart(10'd40);
    BranchEn = 1'b1; Taken = 1'b0; LutIdx = 3'd3; tick();
    BranchEn = 1'b0;
    chk("nottaken.pc", 32'(ProgCtr), 32'd41);

    // Halt wins over taken branch.
    restart(10'd10);
    expect_out("pre_halt", 10'd10, 1'b1, 1'b0, 16'd0);
    Halt = 1'b1; BranchEn = 1'b1; Taken = 1'b1; LutIdx = 3'd3; tick();
    Halt = 1'b0; BranchEn = 1'b0; Taken = 1'b0;
    expect_out("halt_prio", 10'd10, 1'b0, 1'b1, 16'd1);
    // Decode inputs ignored outside RUN; count frozen.
    BranchEn = 1'b1; Taken = 1'b1; LutIdx = 3'd2; tick(); tick();
    BranchEn = 1'b0; Taken = 1'b0;
    expect_out("halt_frozen", 10'd10, 1'b0, 1'b1, 16'd1);

    // Restart from HALTED at 100, then a Start pulse in RUN is ignored.
    Start = 1'b1; StartAddr = 10'd100; tick(); Start = 1'b0;
    expect_out("restart100", 10'd100, 1'b1, 1'b0, 16'd0);
    Start = 1'b1; StartAddr = 10'd200; tick(); Start = 1'b0;
    expect_out("start_ignored", 10'd101, 1'b1, 1'b0, 16'd1);

    // Async reset mid-RUN at PC=7, between edges.
    restart(10'd7);
    chk("mid.pc7", 32'(ProgCtr), 32'd7);
    #2 Reset = 1'b1;
    #1 expect_out("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
    #1 Reset = 1'b0;
    tick(); tick();
    expect_out("post_rst_idle", 10'd0, 1'b0, 1'b0, 16'd0);
    Start = 1'b1; StartAddr = 10'd3; tick(); Start = 1'b0;
    expect_out("post_rst_start", 10'd3, 1'b1, 1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
